// File: rtl/lsu_mem_ctrl.sv
// Load/store unit stage: at most one memory access per accepted instruction, with byte-lane
// steering for stores and extract/extend for loads. Optional build macro: LSU_MISALIGN_CHECK_EN.
module lsu_mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mem_en,
  input  logic              mem_wr,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       lsu_data,
  output logic              lsu_sel,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data
`ifdef LSU_MISALIGN_CHECK_EN
  ,
  output logic              misalign_err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_mem_en;
  logic              r_mem_wr;
  logic              r_misalign;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;

  logic              w_accept;
  logic              w_in_misalign;
  logic              w_req;
  logic              w_done;
  logic [1:0]        w_off;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load_ext;
  logic [31:0]       w_st_data;
  logic [3:0]        w_st_mask;

  assign w_accept = in_valid & in_ready;
  assign w_req    = (r_state == S_REQ);
  assign w_done   = (r_state == S_DONE);
  assign w_off    = r_addr[1:0];

`ifdef LSU_MISALIGN_CHECK_EN
  // The offset must be a multiple of the access size; byte accesses can never misalign.
  always_comb begin
    w_in_misalign = 1'b0;
    if (mem_en) begin
      case (funct3[1:0])
        2'b00:   w_in_misalign = 1'b0;
        2'b01:   w_in_misalign = addr[0];
        default: w_in_misalign = |addr[1:0];
      endcase
    end
  end

  assign misalign_err = w_done & r_misalign;
`else
  assign w_in_misalign = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next_state = (mem_en && !w_in_misalign) ? S_REQ : S_DONE;
      S_REQ:  if (mem_req_ready) w_next_state = S_WAIT;
      S_WAIT: if (mem_rsp_valid) w_next_state = S_DONE;
      S_DONE: if (out_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments make every register sample pre-edge values; the latched
  // fields are cleared on reset too, so the request and result outputs read 0 afterwards.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_mem_en   <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_misalign <= 1'b0;
      r_funct3   <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_mem_en   <= mem_en;
        r_mem_wr   <= mem_wr;
        r_misalign <= w_in_misalign;
        r_funct3   <= funct3;
        r_addr     <= addr;
        r_wdata    <= wdata;
      end
      if (r_state == S_WAIT && mem_rsp_valid) r_rdata <= w_load_ext;
    end
  end

  // funct3[1:0] gives the size (illegal encodings fall to word), funct3[2] selects zero-extension.
  always_comb begin
    w_byte = mem_rsp_data[{w_off, 3'b000} +: 8];
    w_half = w_off[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
    case (r_funct3[1:0])
      2'b00:   w_load_ext = {{24{~r_funct3[2] & w_byte[7]}}, w_byte};
      2'b01:   w_load_ext = {{16{~r_funct3[2] & w_half[15]}}, w_half};
      default: w_load_ext = mem_rsp_data;
    endcase
  end

  always_comb begin
    case (r_funct3[1:0])
      2'b00: begin
        w_st_mask = 4'b0001 << w_off;
        w_st_data = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_st_mask = 4'b0011 << {w_off[1], 1'b0};
        w_st_data = {2{r_wdata[15:0]}};
      end
      default: begin
        w_st_mask = 4'b1111;
        w_st_data = r_wdata;
      end
    endcase
  end

  assign in_ready      = (r_state == S_IDLE);
  assign mem_req_valid = w_req;
  assign mem_addr      = w_req ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wen       = w_req & r_mem_wr;
  assign mem_wdata     = w_req ? w_st_data : '0;
  assign mem_wmask     = w_req ? w_st_mask : '0;

  assign out_valid = w_done;
  assign lsu_sel   = w_done & r_mem_en & ~r_mem_wr & ~r_misalign;
  assign lsu_data  = lsu_sel ? r_rdata : '0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized bench for lsu_mem_ctrl: a byte-level reference model plus a per-cycle compare
// process, with directed transactions whose results are pinned to hand-computed literals.
`timescale 1ns/1ps
module tb_lsu_mem_ctrl;
  localparam int ADDR_W = 32;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, mem_en, mem_wr;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        out_valid, out_ready, lsu_sel;
  logic [31:0] lsu_data;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rsp_data;
  logic [3:0]  mem_wmask;
`ifdef LSU_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  // transaction currently owned by the DUT, as the model sees it
  logic        cur_en, cur_wr;
  logic [2:0]  cur_f3;
  logic [31:0] cur_addr, cur_wd, cur_rsp;

  // DUT observations from the last run_txn, for literal checks
  int          obs_lat;
  logic [31:0] obs_addr, obs_wdata, obs_data;
  logic [3:0]  obs_mask;
  logic        obs_wen, obs_sel, obs_mis;
  logic        exp_load;

  always #5 clock = ~clock;

  lsu_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .mem_en(mem_en), .mem_wr(mem_wr), .funct3(funct3), .addr(addr), .wdata(wdata),
    .out_valid(out_valid), .out_ready(out_ready), .lsu_data(lsu_data), .lsu_sel(lsu_sel),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
`ifdef LSU_MISALIGN_CHECK_EN
    , .misalign_err(misalign_err)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int acc_bytes(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  // first byte lane touched: offset rounded down to a multiple of the access size
  function automatic int lane0(input logic [2:0] f3, input logic [31:0] a);
    int s = acc_bytes(f3);
    return (int'(a[1:0]) / s) * s;
  endfunction

  function automatic logic [3:0] m_mask(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] m = '0;
    int s  = acc_bytes(f3);
    int st = lane0(f3, a);
    for (int k = 0; k < 4; k++) if (k >= st && k < st + s) m[k] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int s = acc_bytes(f3);
    for (int k = 0; k < 4; k++) r[8*k +: 8] = wd[8*(k % s) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rd);
    int     s    = acc_bytes(f3);
    int     st   = lane0(f3, a);
    longint v    = 0;
    longint span = longint'(1) << (8 * s);
    v[31:0] = rd >> (8 * st);
    v = v % span;
    if (f3 == 3'b000 || f3 == 3'b001) if (v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  function automatic logic m_mis(input logic en, input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_CHECK_EN
    return en && ((int'(a[1:0]) % acc_bytes(f3)) != 0);
`else
    return 1'b0 & en & f3[0] & a[0];
`endif
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (cmp_en) begin
      if (out_valid !== 1'b1) begin
        check("sel_when_idle", {31'b0, lsu_sel}, 32'd0);
        check("data_when_idle", lsu_data, 32'd0);
      end else begin
        exp_load = cur_en && !cur_wr && !m_mis(cur_en, cur_f3, cur_addr);
        check("lsu_sel", {31'b0, lsu_sel}, {31'b0, exp_load});
        check("lsu_data", lsu_data, exp_load ? m_load(cur_f3, cur_addr, cur_rsp) : 32'd0);
      end
      if (mem_req_valid === 1'b1) begin
        check("req_addr", mem_addr, {cur_addr[31:2], 2'b00});
        check("req_wen", {31'b0, mem_wen}, {31'b0, cur_wr});
        if (cur_wr) begin
          check("req_wmask", {28'b0, mem_wmask}, {28'b0, m_mask(cur_f3, cur_addr)});
          check("req_wdata", mem_wdata, m_wdata(cur_f3, cur_wd));
        end
      end
`ifdef LSU_MISALIGN_CHECK_EN
      check("misalign_err", {31'b0, misalign_err},
            {31'b0, (out_valid === 1'b1) && m_mis(cur_en, cur_f3, cur_addr)});
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic noise_inputs();
    in_valid = 1'b1;
    mem_en   = 1'($urandom_range(0, 1));
    mem_wr   = 1'($urandom_range(0, 1));
    funct3   = 3'($urandom_range(0, 7));
    addr     = $urandom;
    wdata    = $urandom;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_txn(input logic en, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rsp,
                         input int req_d, input int rsp_d, input int out_d);
    logic go_mem;
    int   t;
    go_mem  = en && !m_mis(en, f3, a);
    obs_lat = -1;
    check("pre_in_ready", {31'b0, in_ready}, 32'd1);
    cur_en = en; cur_wr = wr; cur_f3 = f3; cur_addr = a; cur_wd = wd; cur_rsp = rsp;
    in_valid = 1'b1; mem_en = en; mem_wr = wr; funct3 = f3; addr = a; wdata = wd;
    @(negedge clock);
    t = 1;
    if (go_mem) begin
      for (int k = 0; k <= req_d; k++) begin
        check("req_phase_valid", {31'b0, mem_req_valid}, 32'd1);
        check("req_phase_in_ready", {31'b0, in_ready}, 32'd0);
        check("req_phase_out_valid", {31'b0, out_valid}, 32'd0);
        if (k == 0) begin
          obs_addr = mem_addr; obs_wen = mem_wen; obs_mask = mem_wmask; obs_wdata = mem_wdata;
        end
        mem_req_ready = (k == req_d);
        mem_rsp_valid = 1'($urandom_range(0, 1));
        mem_rsp_data  = $urandom;
        noise_inputs();
        @(negedge clock);
        t++;
      end
      mem_req_ready = 1'b0;
      for (int k = 0; k <= rsp_d; k++) begin
        check("wait_phase_req_valid", {31'b0, mem_req_valid}, 32'd0);
        check("wait_phase_out_valid", {31'b0, out_valid}, 32'd0);
        check("wait_phase_in_ready", {31'b0, in_ready}, 32'd0);
        mem_rsp_valid = (k == rsp_d);
        mem_rsp_data  = (k == rsp_d) ? rsp : $urandom;
        noise_inputs();
        @(negedge clock);
        t++;
      end
    end
    for (int k = 0; k <= out_d; k++) begin
      check("done_out_valid", {31'b0, out_valid}, 32'd1);
      check("done_req_valid", {31'b0, mem_req_valid}, 32'd0);
      check("done_in_ready", {31'b0, in_ready}, 32'd0);
      if (k == 0) begin
        obs_lat = t; obs_data = lsu_data; obs_sel = lsu_sel;
`ifdef LSU_MISALIGN_CHECK_EN
        obs_mis = misalign_err;
`else
        obs_mis = 1'b0;
`endif
      end
      out_ready     = (k == out_d);
      mem_rsp_valid = 1'($urandom_range(0, 1));
      mem_rsp_data  = $urandom;
      if (k == out_d) in_valid = 1'b0;
      else noise_inputs();
      @(negedge clock);
      t++;
    end
    out_ready = 1'b0; mem_rsp_valid = 1'b0; in_valid = 1'b0;
    check("post_out_valid", {31'b0, out_valid}, 32'd0);
    check("post_in_ready", {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; mem_en = 1'b0; mem_wr = 1'b0; funct3 = '0; addr = '0; wdata = '0;
    out_ready = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    cur_en = 1'b0; cur_wr = 1'b0; cur_f3 = '0; cur_addr = '0; cur_wd = '0; cur_rsp = '0;
    repeat (3) @(negedge clock);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
    check("rst_lsu_data", lsu_data, 32'd0);
    check("rst_lsu_sel", {31'b0, lsu_sel}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wen", {31'b0, mem_wen}, 32'd0);
    check("rst_mem_wmask", {28'b0, mem_wmask}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    reset  = 1'b0;
    cmp_en = 1'b1;

    // non-memory op: result one cycle after the handshake
    run_txn(1'b0, 1'b0, 3'b010, 32'h1234_5678, 32'hCAFE_F00D, 32'h0BAD_0BAD, 0, 0, 0);
    check("nonmem_latency", obs_lat, 32'd1);
    check("nonmem_sel", {31'b0, obs_sel}, 32'd0);
    check("nonmem_data", obs_data, 32'd0);

    // LB / LBU on the top byte lane
    run_txn(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80AA_BBCC, 0, 0, 0);
    check("lb_latency", obs_lat, 32'd3);
    check("lb_mem_addr", obs_addr, 32'h8000_0000);
    check("lb_mem_wen", {31'b0, obs_wen}, 32'd0);
    check("lb_data", obs_data, 32'hFFFF_FF80);
    check("lb_sel", {31'b0, obs_sel}, 32'd1);
    run_txn(1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'h0, 32'h80AA_BBCC, 0, 0, 0);
    check("lbu_data", obs_data, 32'h0000_0080);

    // SH with request and result backpressure while new instructions are offered
    run_txn(1'b1, 1'b1, 3'b001, 32'h0000_0102, 32'h1234_5678, 32'h5555_AAAA, 3, 1, 2);
    check("sh_wmask", {28'b0, obs_mask}, 32'h0000_000C);
    check("sh_wdata", obs_wdata, 32'h5678_5678);
    check("sh_wen", {31'b0, obs_wen}, 32'd1);
    check("sh_sel", {31'b0, obs_sel}, 32'd0);
    check("sh_data", obs_data, 32'd0);

    // LH upper half with the same stalls
    run_txn(1'b1, 1'b0, 3'b001, 32'h0000_1002, 32'h0, 32'h8001_7FFF, 3, 2, 2);
    check("lh_data", obs_data, 32'hFFFF_8001);

    // misaligned word load
    run_txn(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
`ifdef LSU_MISALIGN_CHECK_EN
    check("lw_mis_latency", obs_lat, 32'd1);
    check("lw_mis_err", {31'b0, obs_mis}, 32'd1);
    check("lw_mis_data", obs_data, 32'd0);
`else
    check("lw_mis_latency", obs_lat, 32'd3);
    check("lw_mis_addr", obs_addr, 32'h0000_0004);
    check("lw_mis_data", obs_data, 32'hDEAD_BEEF);
`endif

    // reset while waiting for the response; a late response must be ignored
    cur_en = 1'b1; cur_wr = 1'b0; cur_f3 = 3'b010; cur_addr = 32'h0000_0040;
    cur_wd = '0; cur_rsp = '0;
    in_valid = 1'b1; mem_en = 1'b1; mem_wr = 1'b0; funct3 = 3'b010; addr = 32'h0000_0040;
    @(negedge clock);
    in_valid = 1'b0;
    check("rw_req_valid", {31'b0, mem_req_valid}, 32'd1);
    mem_req_ready = 1'b1;
    @(negedge clock);
    mem_req_ready = 1'b0;
    check("rw_wait_req_valid", {31'b0, mem_req_valid}, 32'd0);
    check("rw_wait_in_ready", {31'b0, in_ready}, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("rw_rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rw_rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
    check("rw_rst_out_valid", {31'b0, out_valid}, 32'd0);
    reset = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h7777_7777;
    @(negedge clock);
    mem_rsp_valid = 1'b0;
    check("rw_late_out_valid", {31'b0, out_valid}, 32'd0);
    check("rw_late_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clock);
    check("rw_late_out_valid2", {31'b0, out_valid}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      run_txn(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store unit stage of the multicycle core; sits between the execute stage and the write-back stage.
Accepts one instruction per valid/ready handshake and issues at most one memory request over a simple request/response bus.
Byte lanes are handled on the way out (store mask and data shift) and on the way back (load extract and sign/zero extension).
Produces the load result and a load-select flag that the write-back mux consumes.

Parameters:
ADDR_W, 32, width of addr and mem_addr; data width is fixed at 32.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream instruction valid
in_ready  output  1  high only in IDLE
mem_en  input  1  instruction is a load or store
mem_wr  input  1  1 = store, 0 = load (meaningful only when mem_en=1)
funct3  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr  input  ADDR_W  effective byte address
wdata  input  32  store source register value
out_valid  output  1  result valid to write-back
out_ready  input  1  write-back accepts result
lsu_data  output  32  extended load result
lsu_sel  output  1  1 = write-back uses lsu_data (loads only)
mem_req_valid  output  1  memory request valid
mem_req_ready  input  1  memory accepts request
mem_addr  output  ADDR_W  word-aligned address {addr[ADDR_W-1:2], 2'b00}
mem_wen  output  1  request is a write
mem_wdata  output  32  lane-shifted store data
mem_wmask  output  4  byte-enable mask
mem_rsp_valid  input  1  read data returned, or write acknowledged
mem_rsp_data  input  32  read data word

Behaviour:
- Reset: state=IDLE; in_ready=1; all other outputs 0; latched fields cleared. Reset in any state abandons the operation, and mem_req_valid is 0 from the next cycle.
- Capture: in_valid & in_ready latches mem_en, mem_wr, funct3, addr and wdata. Inputs are ignored outside IDLE.
- States: IDLE, REQ, WAIT, DONE.
  - IDLE -> REQ on handshake with mem_en=1.
  - IDLE -> DONE on handshake with mem_en=0.
  - REQ: mem_req_valid=1; mem_addr, mem_wen, mem_wdata and mem_wmask held stable; -> WAIT when mem_req_ready=1.
  - WAIT: -> DONE on mem_rsp_valid=1; load data is captured that same cycle.
  - DONE: out_valid=1 with lsu_data and lsu_sel stable; -> IDLE when out_ready=1.
- mem_rsp_valid is ignored in IDLE, REQ and DONE.
- Latency (handshake at edge N, memory ready immediately, response the cycle after):
  - Non-memory op: out_valid from N+1.
  - Memory op: REQ at N+1, WAIT at N+2, rsp_valid at N+2, out_valid at N+3.
  - out_valid is held until out_ready.
- Store mask and data, with o=addr[1:0]:
  - B: mask 4'b0001<<o; data {4{wdata[7:0]}}.
  - H: mask 4'b0011<<{o[1],1'b0}; data {2{wdata[15:0]}}.
  - W: mask 4'b1111; data wdata.
  - funct3 011, 110, 111 are treated as W.
  - Stores wait for the mem_rsp_valid acknowledge; response data is discarded.
- Load extract:
  - B/BU: byte at o, sign- or zero-extended.
  - H/HU: half at o[1], extended the same way.
  - W: full word.
  - Illegal funct3 is treated as W.
- Select and data:
  - Load: lsu_sel=1.
  - Store or non-memory op: lsu_sel=0 and lsu_data=0.
  - lsu_sel and lsu_data are 0 whenever out_valid=0.
- Misalignment without the macro: low address bits below the access size are ignored (H uses o[1]; W uses no offset).

Optional Feature:
Macro LSU_MISALIGN_CHECK_EN.
- Defined: adds output misalign_err (1 bit).
  - Misaligned cases: H/HU with addr[0]=1, or W with addr[1:0]!=0, while mem_en=1.
  - A misaligned op goes IDLE -> DONE with no memory request.
  - In DONE: misalign_err=1, lsu_sel=0, lsu_data=0; all held with out_valid.
  - misalign_err is 0 at all other times.
- Undefined: no port; the ignore-low-bits rule applies.

Test Plan:
- Non-memory op (mem_en=0), out_ready=1 -> out_valid exactly 1 cycle after the handshake; lsu_sel=0, lsu_data=0; no mem_req_valid.
- LB addr=0x8000_0003, mem_rsp_data=0x80AA_BBCC -> mem_addr=0x8000_0000, mem_wen=0, lsu_data=0xFFFF_FF80, lsu_sel=1. The same access with LBU -> lsu_data=0x0000_0080.
- SH addr=0x0000_0102, wdata=0x1234_5678 -> mem_wmask=4'b1100, mem_wdata=0x5678_5678, mem_wen=1; out_valid only after mem_rsp_valid; lsu_sel=0.
- Backpressure: mem_req_ready low for 3 cycles, then out_ready low for 2 cycles after the response -> request fields stable, out_valid and lsu_data held, in_ready=0 throughout; a second in_valid during the stall is not captured.
- Reset asserted in WAIT -> next cycle state IDLE, in_ready=1, mem_req_valid=0; a late mem_rsp_valid is ignored.
- With LSU_MISALIGN_CHECK_EN: LW addr=0x0000_0006 -> no mem_req_valid, out_valid next cycle, misalign_err=1, lsu_data=0.
